// File: rtl/poop_dispatcher.sv
// poop_dispatcher: turns the fire button into one-hot deploy pulses, picks the
// lowest free poop slot, latches the bird position as launch coordinates and
// keeps per-slot occupancy (lifetime timeout or external release).
//
// Output handshake: deploy_poop and fire_dropped are valid-only pulses with no
// ready/backpressure. A set bit means "this cycle" and the pulse lasts exactly
// one clock; the consumer must sample it on the cycle it is high.
module poop_dispatcher #(
   parameter int NUM_OF_POOPS    = 8,
   parameter int COOLDOWN_FRAMES = 4,
   parameter int LIFETIME_FRAMES = 120
) (
   input  logic                                    clk,
   input  logic                                    resetN,
   input  logic                                    startOfFrame,
   input  logic                                    fire_request,
   input  logic signed [10:0]                      bird_x,
   input  logic signed [10:0]                      bird_y,
   input  logic [NUM_OF_POOPS-1:0]                 slot_release,
   output logic [NUM_OF_POOPS-1:0]                 deploy_poop,
   output logic signed [NUM_OF_POOPS-1:0][1:0][10:0] initial_coordinates,
   output logic [NUM_OF_POOPS-1:0]                 slots_busy,
   output logic                                    fire_dropped,
   output logic [1:0]                              dbg_state
);

   localparam int LW = $clog2(LIFETIME_FRAMES + 1);
   localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
   localparam int IW = (NUM_OF_POOPS > 1) ? $clog2(NUM_OF_POOPS) : 1;

   typedef enum logic [1:0] {
      READY    = 2'd0,
      FIRE     = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   state_t                   state;
   logic [CW-1:0]            cool_cnt;
   logic                     fire_prev;
   logic [LW-1:0]            life_cnt [NUM_OF_POOPS];

   logic                     fire_edge;
   logic                     free_found;
   logic [IW-1:0]            free_idx;
   logic                     take;
   logic                     drop;
   logic [NUM_OF_POOPS-1:0]  deploy_mask;

   assign dbg_state = state;

   // Lowest-index free slot, from the registered occupancy so a slot freed
   // this cycle only becomes allocatable next cycle.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_OF_POOPS - 1; i >= 0; i--) begin
         if (!slots_busy[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   assign fire_edge   = fire_request & ~fire_prev;
   assign take        = (state == READY) && fire_edge && free_found;
   assign drop        = (state == READY) && fire_edge && !free_found;
   assign deploy_mask = NUM_OF_POOPS'(1) << free_idx;

   // Shot FSM: edge detect, deploy/drop pulses and the frame-based cooldown.
   always_ff @(posedge clk) begin
      if (resetN) begin
         state        <= READY;
         cool_cnt     <= '0;
         fire_prev    <= 1'b1;
         deploy_poop  <= '0;
         fire_dropped <= 1'b0;
      end else begin
         fire_prev    <= fire_request;
         deploy_poop  <= '0;
         fire_dropped <= 1'b0;
         case (state)
            READY: begin
               if (take) begin
                  state       <= FIRE;
                  deploy_poop <= deploy_mask;
               end else if (drop) begin
                  fire_dropped <= 1'b1;
               end
            end
            FIRE: begin
               // Frame pulses during this cycle are deliberately not counted.
               state    <= COOLDOWN;
               cool_cnt <= CW'(COOLDOWN_FRAMES);
            end
            COOLDOWN: begin
               if (startOfFrame) begin
                  cool_cnt <= cool_cnt - CW'(1);
                  if (cool_cnt == CW'(1)) begin
                     state <= READY;
                  end
               end
            end
            default: begin
               state <= READY;
            end
         endcase
      end
   end

   // Slot bookkeeping: allocation, coordinate latch, lifetime and release.
   always_ff @(posedge clk) begin
      if (resetN) begin
         slots_busy          <= '0;
         initial_coordinates <= '0;
         for (int k = 0; k < NUM_OF_POOPS; k++) begin
            life_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_OF_POOPS; k++) begin
            if (take && (int'(free_idx) == k)) begin
               // New slot starts a full lifetime; a frame pulse now is ignored.
               slots_busy[k]             <= 1'b1;
               life_cnt[k]               <= LW'(LIFETIME_FRAMES);
               initial_coordinates[k][0] <= bird_x;
               initial_coordinates[k][1] <= bird_y;
            end else if (slots_busy[k]) begin
               // Counter only moves while busy, so it never wraps.
               if (startOfFrame) begin
                  life_cnt[k] <= life_cnt[k] - LW'(1);
               end
               if (slot_release[k] || (startOfFrame && life_cnt[k] == LW'(1))) begin
                  slots_busy[k] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_poop_dispatcher.sv
// Bench for poop_dispatcher: two instances (default lifetime and a short
// lifetime of 3 frames) share stimulus; a per-instance reference model feeds
// expected deploy/drop events into queues that a monitor drains.
module tb_poop_dispatcher;

  localparam int COOL   = 4;
  localparam int LIFE_A = 120;
  localparam int LIFE_B = 3;
  localparam int EW     = 31;  // {is_drop, mask[7:0], y[10:0], x[10:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst  = 1'b1;
  logic              sof  = 1'b0;
  logic              fire = 1'b0;
  logic signed [10:0] bx  = '0;
  logic signed [10:0] by  = '0;
  logic [7:0]        rel  = '0;

  logic [7:0]            dep_a, dep_b, busy_a, busy_b;
  logic                  drop_a, drop_b;
  logic [1:0]            dbg_a, dbg_b;
  logic [7:0][1:0][10:0] coords_a, coords_b;

  poop_dispatcher #(.NUM_OF_POOPS(8), .COOLDOWN_FRAMES(COOL), .LIFETIME_FRAMES(LIFE_A)) dut_a (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .fire_request(fire),
    .bird_x(bx), .bird_y(by), .slot_release(rel),
    .deploy_poop(dep_a), .initial_coordinates(coords_a), .slots_busy(busy_a),
    .fire_dropped(drop_a), .dbg_state(dbg_a)
  );

  poop_dispatcher #(.NUM_OF_POOPS(8), .COOLDOWN_FRAMES(COOL), .LIFETIME_FRAMES(LIFE_B)) dut_b (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .fire_request(fire),
    .bird_x(bx), .bird_y(by), .slot_release(rel),
    .deploy_poop(dep_b), .initial_coordinates(coords_b), .slots_busy(busy_b),
    .fire_dropped(drop_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: a mode (ready / shooting / cooling with frames left),
  // a set of busy slots each with frames of life remaining, and launch points.
  int               m_mode [2];   // 0 ready, 1 shooting, 2 cooling
  int               m_cool [2];
  bit               m_prev [2];
  logic [7:0]       m_busy [2];
  int               m_life [2][8];
  logic [10:0]      m_x    [2][8];
  logic [10:0]      m_y    [2][8];

  task automatic push_exp(input int i, input logic [EW-1:0] e);
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic model_step(input int i);
    logic [7:0] nb;
    bit fe;
    int k;
    if (rst) begin
      m_mode[i] = 0; m_cool[i] = 0; m_prev[i] = 1'b1; m_busy[i] = '0;
      for (int s = 0; s < 8; s++) begin
        m_life[i][s] = 0; m_x[i][s] = '0; m_y[i][s] = '0;
      end
      return;
    end
    fe = fire && !m_prev[i];
    m_prev[i] = fire;
    nb = m_busy[i];
    for (int s = 0; s < 8; s++) begin
      if (m_busy[i][s]) begin
        if (sof) begin
          m_life[i][s] = m_life[i][s] - 1;
          if (m_life[i][s] == 0) nb[s] = 1'b0;
        end
        if (rel[s]) nb[s] = 1'b0;
      end
    end
    case (m_mode[i])
      0: begin
        if (fe) begin
          k = -1;
          for (int s = 7; s >= 0; s--) if (!m_busy[i][s]) k = s;
          if (k >= 0) begin
            nb[k] = 1'b1;
            m_life[i][k] = (i == 0) ? LIFE_A : LIFE_B;
            m_x[i][k] = bx;
            m_y[i][k] = by;
            push_exp(i, {1'b0, 8'(1 << k), by, bx});
            m_mode[i] = 1;
          end else begin
            push_exp(i, {1'b1, 8'h00, 22'h0});
          end
        end
      end
      1: begin
        m_mode[i] = 2;
        m_cool[i] = COOL;
      end
      default: begin
        if (sof) begin
          m_cool[i] = m_cool[i] - 1;
          if (m_cool[i] == 0) m_mode[i] = 0;
        end
      end
    endcase
    m_busy[i] = nb;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- monitor ----------------
  task automatic mon_inst(input int i, input logic [7:0] dep, input logic drop,
                          input logic [7:0] busy, input logic [175:0] co);
    logic [EW-1:0]  e;
    logic [175:0]   exp_co;
    int             slot;
    int             qs;
    qs = (i == 0) ? exp_q0.size() : exp_q1.size();
    if (dep != 8'h00 || drop) begin
      if (qs == 0) begin
        cmp($sformatf("unexpected_output_%0d", i), {dep, drop}, 0);
      end else begin
        if (i == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        cmp($sformatf("deploy_mask_%0d", i), dep, e[29:22]);
        cmp($sformatf("fire_dropped_%0d", i), drop, e[30]);
        if (!e[30]) begin
          slot = 0;
          for (int s = 0; s < 8; s++) if (e[22+s]) slot = s;
          cmp($sformatf("launch_coords_%0d", i), co[slot*22 +: 22], e[21:0]);
        end
      end
    end
    qs = (i == 0) ? exp_q0.size() : exp_q1.size();
    if (qs != 0) begin
      cmp($sformatf("missing_output_%0d", i), qs, 0);
      if (i == 0) exp_q0.delete();
      else        exp_q1.delete();
    end
    cmp($sformatf("slots_busy_%0d", i), busy, m_busy[i]);
    for (int s = 0; s < 8; s++) exp_co[s*22 +: 22] = {m_y[i][s], m_x[i][s]};
    cmp($sformatf("coords_%0d", i), co, exp_co);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_inst(0, dep_a, drop_a, busy_a, coords_a);
        mon_inst(1, dep_b, drop_b, busy_b, coords_b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit s, input bit f, input logic [7:0] rl);
    @(negedge clk);
    rst  = r;
    sof  = s;
    fire = f;
    rel  = rl;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
  endtask

  task automatic shot(input bit sof_on_edge);
    bx = 11'($urandom_range(0, 2047));
    by = 11'($urandom_range(0, 2047));
    drive(0, sof_on_edge, 1, 8'h00);
    drive(0, 0, 0, 8'h00);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      drive(0, 1, 0, 8'h00);
      drive(0, 0, 0, 8'h00);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [21:0] slot3_model;
  bit          f_lvl;

  initial begin
    do_reset();
    mon_en = 1'b1;
    cmp("reset_busy", busy_a, 8'h00);
    cmp("reset_deploy", dep_a, 8'h00);
    cmp("reset_dropped", drop_a, 1'b0);
    cmp("reset_state", dbg_a, 2'd0);
    cmp("reset_coords", coords_a, 176'h0);

    // Basic deploy
    bx = 11'sd100; by = 11'sd40;
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("basic_deploy", dep_a, 8'b0000_0001);
    cmp("basic_busy", busy_a, 8'b0000_0001);
    cmp("basic_coords", coords_a[0], {11'sd40, 11'sd100});
    drive(0, 0, 0, 8'h00);
    cmp("basic_pulse_width", dep_a, 8'h00);

    // Cooldown: edges before the 4th frame pulse do nothing
    frames(2);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("cool_no_deploy", dep_a, 8'h00);
    cmp("cool_no_drop", drop_a, 1'b0);
    frames(1);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("cool_no_deploy2", dep_a, 8'h00);
    frames(1);
    shot(0);
    cmp("cool_then_slot1", dep_a, 8'b0000_0010);
    frames(COOL);

    // Fill the remaining slots
    for (int n = 0; n < 6; n++) begin
      shot(0);
      frames(COOL);
    end
    cmp("full_busy", busy_a, 8'hFF);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("full_dropped", drop_a, 1'b1);
    cmp("full_no_deploy", dep_a, 8'h00);
    cmp("full_still_busy", busy_a, 8'hFF);
    drive(0, 0, 0, 8'h00);
    cmp("dropped_pulse_width", drop_a, 1'b0);

    // Release slot 2 and reuse it
    drive(0, 0, 0, 8'b0000_0100);
    drive(0, 0, 0, 8'h00);
    cmp("release_busy", busy_a, 8'hFB);
    slot3_model = {m_y[0][3], m_x[0][3]};
    bx = -11'sd300; by = 11'sd77;
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("reuse_deploy", dep_a, 8'b0000_0100);
    cmp("reuse_coords", coords_a[2], {11'sd77, -11'sd300});
    cmp("reuse_slot3_hold", coords_a[3], slot3_model);
    frames(COOL);

    // Lifetime of 3 with frame pulse on the deploy cycle, then release+timeout together
    do_reset();
    shot(1);
    cmp("life_deploy_b", dep_b, 8'b0000_0001);
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("life_still_busy_b", busy_b, 8'b0000_0001);
    drive(0, 1, 0, 8'b0000_0001);
    drive(0, 0, 0, 8'h00);
    cmp("life_freed_b", busy_b, 8'h00);
    cmp("release_freed_a", busy_a, 8'h00);
    frames(2);

    // Fire held through reset never fires
    drive(1, 0, 1, 8'h00);
    drive(1, 0, 1, 8'h00);
    drive(1, 0, 1, 8'h00);
    repeat (6) begin
      drive(0, 0, 1, 8'h00);
      cmp("held_no_deploy", dep_a, 8'h00);
    end
    drive(0, 0, 0, 8'h00);

    // Reset mid-cooldown with three busy slots
    shot(0); frames(COOL);
    shot(0); frames(COOL);
    shot(0);
    drive(0, 1, 0, 8'h00);
    cmp("pre_reset_busy", busy_a, 8'b0000_0111);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("mid_reset_busy", busy_a, 8'h00);
    cmp("mid_reset_coords", coords_a, 176'h0);
    cmp("mid_reset_deploy", dep_a, 8'h00);
    cmp("mid_reset_dropped", drop_a, 1'b0);
    cmp("mid_reset_state", dbg_a, 2'd0);

    // Randomized traffic against the model
    f_lvl = 1'b0;
    repeat (3000) begin
      bx = 11'($urandom_range(0, 2047));
      by = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 2) == 0) f_lvl = ~f_lvl;
      drive(($urandom_range(0, 599) == 0),
            ($urandom_range(0, 5) == 0),
            f_lvl,
            ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
    end
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    cmp("queues_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poop_dispatcher.md
# poop_dispatcher

Upstream stage of the poop subsystem. Converts the player's fire button into one-cycle `deploy_poop` pulses and per-slot launch coordinates for the poop top-level. It allocates the lowest-index free slot of `NUM_OF_POOPS`, latches the bird position for that slot, and enforces a frame-based cooldown between shots. It tracks slot occupancy itself; a slot is freed by a lifetime timeout or by an external release pulse.

## Interface
Parameters:
- `NUM_OF_POOPS`, 8: number of slots; must match the poop top-level.
- `COOLDOWN_FRAMES`, 4: minimum `startOfFrame` pulses between shots, ≥1.
- `LIFETIME_FRAMES`, 120: frames a slot stays busy after deploy, ≥1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `resetN`  in  1  synchronous, active-high reset (asserted = 1, sampled on `clk` rising edge).
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `fire_request`  in  1  level fire button.
- `bird_x`  in  11 signed  bird top-left X.
- `bird_y`  in  11 signed  bird top-left Y.
- `slot_release`  in  `NUM_OF_POOPS`  per-slot pulse from collision logic; frees the slot.
- `deploy_poop`  out  `NUM_OF_POOPS`  one-hot, one-cycle deploy pulse.
- `initial_coordinates`  out  `NUM_OF_POOPS`×2×11 signed  per-slot launch {y,x}, index 0 = x.
- `slots_busy`  out  `NUM_OF_POOPS`  slot occupancy.
- `fire_dropped`  out  1  one-cycle pulse: accepted fire edge found no free slot.

## Operation
- Edge detect: `fire_prev` register. A fire edge is `fire_request & ~fire_prev`. `fire_prev` resets to 1, so a button held through reset does not fire.
- FSM states are READY, FIRE and COOLDOWN.
  - READY: on a fire edge with at least one free slot, go to FIRE and register the deploy. On a fire edge with all slots busy, pulse `fire_dropped` and stay in READY.
  - FIRE: lasts one cycle, then go to COOLDOWN and load `cool_cnt = COOLDOWN_FRAMES`.
  - COOLDOWN: decrement `cool_cnt` on each `startOfFrame`. When it decrements from 1 to 0, go to READY. Fire edges in COOLDOWN are ignored: not queued, no `fire_dropped`.
- Slot choice: lowest index k with `slots_busy[k]=0`, computed from the current-cycle `slots_busy`.
- Deploy registers, all on the same edge:
  - `deploy_poop[k]=1` and `slots_busy[k]=1`.
  - `initial_coordinates[k] = {bird_y, bird_x}`, taken unmodified (the downstream stage applies the sprite offsets).
  - `life_cnt[k] = LIFETIME_FRAMES`.
- Other slots' coordinates hold their value. Coordinates are never cleared except by reset.
- Lifetime:
  - While busy, `life_cnt[k]` decrements on each `startOfFrame`. At value 1 with `startOfFrame`, the slot frees.
  - `life_cnt` width is `$clog2(LIFETIME_FRAMES+1)`. No wrap: the counter is never decremented while the slot is free.
- Release: `slot_release[k]=1` clears `slots_busy[k]` next edge. Release of a free slot is ignored. Release and timeout in the same cycle free the slot once.
- Simultaneous events:
  - A slot freed in cycle t is allocatable from cycle t+1, not in t.
  - A `startOfFrame` in the deploy cycle does not decrement the new slot's counter.
  - A `startOfFrame` in the FIRE cycle does not decrement `cool_cnt`.
- Reset: state READY; `cool_cnt`=0; all `slots_busy`, `deploy_poop`, `fire_dropped`, `life_cnt` and `initial_coordinates` = 0; `fire_prev`=1. Reset mid-cooldown or with slots busy discards everything, and no deploy pulse is emitted. Reset has priority over all inputs.

## Timing
- All outputs are registered.
- Fire edge sampled at rising edge t: `deploy_poop[k]`, `initial_coordinates[k]` and `slots_busy[k]` are all valid from t+1. `deploy_poop` is high for exactly one cycle.
- Coordinates are sampled from `bird_x`/`bird_y` at the same edge as the fire edge.
- `fire_dropped` is asserted at t+1 for one cycle.
- Minimum shot spacing: `COOLDOWN_FRAMES` `startOfFrame` pulses after the FIRE cycle.
- Slot freed by release at edge t: `slots_busy` low at t+1.
- Slot freed by timeout: `slots_busy` low on the edge after the `LIFETIME_FRAMES`-th `startOfFrame` counted since deploy.

## Test plan
- **Basic deploy.** Reset, then `bird_x=100`, `bird_y=40` and a one-cycle `fire_request`.
  - Required: `deploy_poop=8'b00000001` for one cycle, `initial_coordinates[0]={40,100}`, `slots_busy=8'b00000001`.
- **Cooldown.**
  - Fire edges before 4 `startOfFrame` pulses produce nothing (no `deploy_poop`, no `fire_dropped`).
  - A fire edge after the 4th pulse deploys slot 1 (`deploy_poop=8'b00000010`).
- **Full condition.** Fill all 8 slots (respecting cooldown), then send another fire edge in READY.
  - Required: `fire_dropped` pulses once, `deploy_poop` stays 0, `slots_busy=8'hFF`.
- **Release and reuse.** All slots busy, pulse `slot_release=8'b00000100`, then fire in READY.
  - Required: `slots_busy[2]` clears next cycle; the deploy goes to slot 2 with new coordinates, and slot 3's coordinates are unchanged.
- **Lifetime and simultaneous events.** `LIFETIME_FRAMES=3`, deploy with `startOfFrame` high in the same cycle.
  - Required: the slot frees after 3 further pulses.
  - `slot_release` and timeout in the same cycle free the slot once, with no glitch.
- **Reset behaviour.** Hold `fire_request=1` through reset, then keep it high.
  - Required: no deploy.
  - Reset asserted mid-cooldown with 3 busy slots clears all outputs to 0 on the next edge.
